// File: rtl/riscv_pkg.sv
// Shared core definitions: reservation FSM states and the default LR/SC
// reservation lifetime.
package riscv_pkg;

    typedef enum logic [0:0] {
        RES_IDLE = 1'b0,
        RES_HELD = 1'b1
    } res_state_e;

    localparam int unsigned DEFAULT_RESERVATION_TIMEOUT = 32'd64;

endpackage

// File: rtl/lr_sc_reservation_unit.sv
// LR/SC reservation tracker for the MA stage: holds one word-granule
// reservation and decides combinationally whether an SC in MA succeeds.
module lr_sc_reservation_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN                = 32,
    parameter int unsigned RESERVATION_TIMEOUT = DEFAULT_RESERVATION_TIMEOUT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_is_lr,
    input  logic            i_is_sc,
    input  logic            i_is_store,
    input  logic [XLEN-1:0] i_data_memory_address,
    input  logic            i_amo_write_enable,
    input  logic [XLEN-1:0] i_amo_write_addr,
    input  logic            i_trap_taken,
    output logic            o_sc_success,
    output logic            o_reservation_valid,
    output logic [XLEN-1:0] o_reservation_addr
);

    localparam int unsigned CNT_W = $clog2(RESERVATION_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(RESERVATION_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    // Clears the byte offset so comparisons and captures work on the word granule.
    localparam logic [XLEN-1:0] WORD_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    // True when two addresses fall in the same aligned word.
    function automatic logic word_match(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        return (((a ^ b) & WORD_MASK) == {XLEN{1'b0}});
    endfunction

    res_state_e        state_r;
    res_state_e        state_s;
    logic [XLEN-1:0]   res_addr_r;
    logic [XLEN-1:0]   res_addr_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              held_s;
    logic              commit_s;
    logic              ma_match_s;
    logic              amo_hit_s;
    logic              store_hit_s;

    assign held_s      = (state_r == RES_HELD);
    assign commit_s    = ~i_stall;
    assign ma_match_s  = word_match(i_data_memory_address, res_addr_r);
    assign amo_hit_s   = i_amo_write_enable & word_match(i_amo_write_addr, res_addr_r);
    assign store_hit_s = i_is_store & commit_s & ma_match_s;
    assign cnt_inc_s   = (cnt_r == TIMEOUT_C) ? cnt_r : (cnt_r + CNT_ONE);

    // SC outcome is visible while the SC sits in MA, stalled or not.
    assign o_sc_success        = i_is_sc & held_s & ma_match_s;
    assign o_reservation_valid = held_s;
    assign o_reservation_addr  = res_addr_r;

    // Next reservation state, address and age; branches are in priority order.
    always_comb begin
        state_s    = state_r;
        res_addr_s = res_addr_r;
        cnt_s      = cnt_r;
        if (i_trap_taken) begin
            state_s = RES_IDLE;
            cnt_s   = CNT_ZERO;
        end else if (i_is_sc && commit_s) begin
            state_s = RES_IDLE;
            cnt_s   = CNT_ZERO;
        end else if (i_is_lr && commit_s) begin
            state_s    = RES_HELD;
            res_addr_s = i_data_memory_address & WORD_MASK;
            cnt_s      = CNT_ZERO;
        end else begin
            case (state_r)
                RES_HELD: begin
                    if (amo_hit_s || store_hit_s) begin
                        state_s = RES_IDLE;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_inc_s == TIMEOUT_C) begin
                        // Age has reached the limit at this edge: drop it now.
                        state_s = RES_IDLE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                RES_IDLE: begin
                    cnt_s = CNT_ZERO;
                end
                default: begin
                    state_s = RES_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Reservation registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= RES_IDLE;
            res_addr_r <= {XLEN{1'b0}};
            cnt_r      <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            res_addr_r <= res_addr_s;
            cnt_r      <= cnt_s;
        end
    end

endmodule

// File: tb/tb_lr_sc_reservation_unit.sv
// Directed bench for the LR/SC reservation unit with hand-computed expectations.
module tb_lr_sc_reservation_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stall;
    logic        i_is_lr;
    logic        i_is_sc;
    logic        i_is_store;
    logic [31:0] i_data_memory_address;
    logic        i_amo_write_enable;
    logic [31:0] i_amo_write_addr;
    logic        i_trap_taken;
    logic        o_sc_success;
    logic        o_reservation_valid;
    logic [31:0] o_reservation_addr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    lr_sc_reservation_unit #(.XLEN(32), .RESERVATION_TIMEOUT(64)) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_stall               (i_stall),
        .i_is_lr               (i_is_lr),
        .i_is_sc               (i_is_sc),
        .i_is_store            (i_is_store),
        .i_data_memory_address (i_data_memory_address),
        .i_amo_write_enable    (i_amo_write_enable),
        .i_amo_write_addr      (i_amo_write_addr),
        .i_trap_taken          (i_trap_taken),
        .o_sc_success          (o_sc_success),
        .o_reservation_valid   (o_reservation_valid),
        .o_reservation_addr    (o_reservation_addr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_rst = 1'b0; i_stall = 1'b0; i_is_lr = 1'b0; i_is_sc = 1'b0;
        i_is_store = 1'b0; i_data_memory_address = 32'h0;
        i_amo_write_enable = 1'b0; i_amo_write_addr = 32'h0; i_trap_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_lr(input logic [31:0] addr);
        i_is_lr = 1'b1; i_data_memory_address = addr;
        tick();
        clear_inputs();
    endtask

    task automatic do_store(input logic [31:0] addr);
        i_is_store = 1'b1; i_data_memory_address = addr;
        tick();
        clear_inputs();
    endtask

    task automatic do_sc(input string tag, input logic [31:0] addr, input logic exp_ok);
        i_is_sc = 1'b1; i_data_memory_address = addr;
        #1;
        check_eq(tag, o_sc_success, exp_ok);
        tick();
        clear_inputs();
        check_eq({tag, "_valid_after"}, o_reservation_valid, 1'b0);
    endtask

    initial begin
        clear_inputs();
        // Reset, with an SC presented to show it cannot succeed.
        i_rst = 1'b1; i_is_sc = 1'b1; i_data_memory_address = 32'h0;
        tick(); tick();
        check_eq("rst_valid", o_reservation_valid, 1'b0);
        check_eq("rst_addr", o_reservation_addr, 32'h0);
        check_eq("rst_sc", o_sc_success, 1'b0);
        clear_inputs();
        tick();

        // LR then SC two cycles later succeeds.
        do_lr(32'h1000);
        check_eq("lr_valid", o_reservation_valid, 1'b1);
        check_eq("lr_addr", o_reservation_addr, 32'h1000);
        tick();
        do_sc("sc_same", 32'h1000, 1'b1);
        check_eq("addr_kept_after_sc", o_reservation_addr, 32'h1000);

        // SC to another word fails and clears.
        do_lr(32'h1000);
        do_sc("sc_other_word", 32'h1004, 1'b0);

        // Matching store (different byte, same word) clears.
        do_lr(32'h2000);
        do_store(32'h2002);
        check_eq("store_match_clears", o_reservation_valid, 1'b0);
        do_sc("sc_after_store_match", 32'h2000, 1'b0);

        // Non-matching store keeps it.
        do_lr(32'h2000);
        do_store(32'h3000);
        check_eq("store_other_keeps", o_reservation_valid, 1'b1);
        do_sc("sc_after_store_other", 32'h2000, 1'b1);

        // Stalled matching store takes no action.
        do_lr(32'h2000);
        i_stall = 1'b1; i_is_store = 1'b1; i_data_memory_address = 32'h2000;
        tick(); clear_inputs();
        check_eq("stalled_store_keeps", o_reservation_valid, 1'b1);
        // Stalled SC reports success but does not consume the reservation.
        i_stall = 1'b1; i_is_sc = 1'b1; i_data_memory_address = 32'h2000;
        #1;
        check_eq("stalled_sc_success", o_sc_success, 1'b1);
        tick(); clear_inputs();
        check_eq("stalled_sc_keeps", o_reservation_valid, 1'b1);
        do_sc("sc_after_stall", 32'h2000, 1'b1);

        // AMO write to the reserved word during a stall clears.
        do_lr(32'h1000);
        i_stall = 1'b1; i_amo_write_enable = 1'b1; i_amo_write_addr = 32'h1000;
        tick(); clear_inputs();
        check_eq("amo_clears", o_reservation_valid, 1'b0);
        do_sc("sc_after_amo", 32'h1000, 1'b0);

        // LR and matching AMO in the same cycle: LR wins.
        i_is_lr = 1'b1; i_data_memory_address = 32'h1000;
        i_amo_write_enable = 1'b1; i_amo_write_addr = 32'h1000;
        tick(); clear_inputs();
        check_eq("lr_beats_amo", o_reservation_valid, 1'b1);

        // LR while held replaces the address; byte offset dropped.
        do_lr(32'h400B);
        check_eq("lr_replace_addr", o_reservation_addr, 32'h4008);
        do_sc("sc_replaced_old", 32'h1000, 1'b0);

        // Timeout boundary: 63 idle cycles survive, 64 do not.
        do_lr(32'h1000);
        repeat (63) tick();
        check_eq("t63_valid", o_reservation_valid, 1'b1);
        do_sc("sc_t63", 32'h1000, 1'b1);
        do_lr(32'h1000);
        repeat (64) tick();
        check_eq("t64_valid", o_reservation_valid, 1'b0);
        do_sc("sc_t64", 32'h1000, 1'b0);

        // Reset mid-reservation discards it.
        do_lr(32'h1000);
        i_rst = 1'b1;
        tick(); clear_inputs();
        check_eq("rst_mid_valid", o_reservation_valid, 1'b0);
        check_eq("rst_mid_addr", o_reservation_addr, 32'h0);
        do_sc("sc_after_rst", 32'h1000, 1'b0);

        // Trap clears but leaves the address visible.
        do_lr(32'h1000);
        i_trap_taken = 1'b1;
        tick(); clear_inputs();
        check_eq("trap_valid", o_reservation_valid, 1'b0);
        check_eq("trap_addr_kept", o_reservation_addr, 32'h1000);
        do_sc("sc_after_trap", 32'h1000, 1'b0);

        // Trap outranks a simultaneous LR.
        i_trap_taken = 1'b1; i_is_lr = 1'b1; i_data_memory_address = 32'h5000;
        tick(); clear_inputs();
        check_eq("trap_beats_lr", o_reservation_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lr_sc_reservation_unit.md
LR_SC_RESERVATION_UNIT -- requirements
Module: lr_sc_reservation_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RESERVATION_TIMEOUT, default 64, cycles a reservation survives without an SC.
REQ-003 SHALL have one clock; reset is synchronous and active-high: i_clk input 1, rising-edge clock.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_stall  input  1  pipeline stall; MA instruction held, no commit this cycle.
REQ-006 i_is_lr  input  1  LR.W in MA.
REQ-007 i_is_sc  input  1  SC.W in MA.
REQ-008 i_is_store  input  1  ordinary store (SB/SH/SW) in MA.
REQ-009 i_data_memory_address  input  XLEN  MA effective address.
REQ-010 i_amo_write_enable  input  1  AMO unit write strobe.
REQ-011 i_amo_write_addr  input  XLEN  AMO unit write address.
REQ-012 i_trap_taken  input  1  exception/interrupt/xRET committed.
REQ-013 o_sc_success  output  1  SC in MA will succeed (combinational).
REQ-014 o_reservation_valid  output  1  reservation held.
REQ-015 o_reservation_addr  output  XLEN  reserved word address, bits [1:0] forced 0.

Function
REQ-016 SHALL implement two states: RES_IDLE, RES_HELD.
REQ-017 Granule SHALL be one aligned word; "match" means address[XLEN-1:2] equal.
REQ-018 An instruction SHALL act only in a cycle with i_stall=0 (commit cycle); stalled cycles take no action.
REQ-019 Committed LR SHALL enter RES_HELD, capture address, load timeout counter to 0; LR while held SHALL replace address and restart counter.
REQ-020 o_sc_success SHALL equal i_is_sc && RES_HELD && match, independent of i_stall.
REQ-021 Committed SC SHALL return to RES_IDLE next cycle whether it succeeded or failed.
REQ-022 Committed i_is_store matching reservation SHALL clear it; non-matching store SHALL not.
REQ-023 i_amo_write_enable with matching i_amo_write_addr SHALL clear reservation regardless of i_stall.
REQ-024 i_trap_taken SHALL clear reservation.
REQ-025 Counter SHALL increment every cycle in RES_HELD (stalled or not), width $clog2(RESERVATION_TIMEOUT+1), saturating; reaching RESERVATION_TIMEOUT SHALL clear reservation next cycle.
REQ-026 Simultaneous-event priority, highest first: reset, trap, SC, LR, AMO/store invalidate, timeout.
REQ-027 LR and matching AMO write in same cycle SHALL leave reservation held (LR wins).
REQ-028 Clearing a reservation SHALL not change o_reservation_addr; only o_reservation_valid drops.

Reset
REQ-029 On i_rst: state RES_IDLE, o_reservation_valid=0, counter=0, o_reservation_addr=0, o_sc_success=0 for non-SC inputs.
REQ-030 Reset mid-reservation SHALL discard it; SC after reset SHALL fail.

Structure
REQ-031 State enum res_state_e and default timeout constant SHALL live in riscv_pkg.
REQ-032 Single flat module; no sub-modules; instantiated in ma_stage beside amo_unit, o_sc_success consumed by store_unit.

Verification
REQ-033 LR 0x1000 committed, SC 0x1000 two cycles later -> o_sc_success=1, valid=0 after SC.
REQ-034 LR 0x1000, SC 0x1004 -> o_sc_success=0, reservation cleared.
REQ-035 LR 0x2000, SW 0x2002 committed, SC 0x2000 -> SC fails; repeat with SW 0x3000 -> SC succeeds.
REQ-036 LR 0x1000, AMO write 0x1000 during stall, SC 0x1000 -> fails.
REQ-037 LR 0x1000, idle 64 cycles, SC -> fails; idle 63 cycles -> succeeds.
REQ-038 LR 0x1000 then i_rst (and separately i_trap_taken) -> valid=0 next cycle, SC fails.
